flex_counter_dir: RTL and testbench

Parametrised bidirectional counter that generalises the fixed down counter used across the pipeline's control path. It adds a selectable count direction, parallel load, and three terminal-count modes: periodic wrap, saturate, and one-shot. Stage controllers use it for row/column walks, kernel-window sequencing and timeouts. All outputs are registered.

---
 rtl/counter_pkg.sv | 13 +
 rtl/flex_counter_dir_if.sv | 28 ++
 rtl/flex_counter_dir.sv | 85 ++++++++
 tb/tb_flex_counter_dir.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the flex_counter_dir family: terminal-count modes and default width.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SATURATE = 2'b01,
        MODE_ONE_SHOT = 2'b10,
        MODE_RSVD     = 2'b11
    } cnt_mode_t;

    localparam int DEFAULT_CNT_BITS = 4;

endpackage

// File: rtl/flex_counter_dir_if.sv
// Control/status bundle between a stage controller (master) and the counter (slave).
interface flex_counter_dir_if #(
    parameter int NUM_CNT_BITS = counter_pkg::DEFAULT_CNT_BITS
);
    import counter_pkg::*;

    logic                    count_enable;
    logic                    up_down;
    cnt_mode_t               mode;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic                    sync_reset;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CNT_BITS-1:0] value;
    logic                    rollover_flag;
    logic                    done;

    modport master (
        output count_enable, up_down, mode, rollover_val, sync_reset, load, load_val,
        input  value, rollover_flag, done
    );

    modport slave (
        input  count_enable, up_down, mode, rollover_val, sync_reset, load, load_val,
        output value, rollover_flag, done
    );

endinterface

// File: rtl/flex_counter_dir.sv
// Bidirectional counter with parallel load and wrap / saturate / one-shot terminal behaviour.
// All outputs come straight from registers.
module flex_counter_dir
    import counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
    input  logic               clk,
    input  logic               rst,
    flex_counter_dir_if.slave  bus
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] value_q, value_d;
    logic                    flag_q, flag_d;
    logic                    done_q, done_d;

    logic [NUM_CNT_BITS-1:0] start_val;
    logic [NUM_CNT_BITS-1:0] stepped;
    logic                    at_terminal;
    logic                    lands_terminal;

    // Start and terminal both follow the live direction, so a flip of up_down
    // takes effect on the very next step without any reload.
    always_comb begin
        start_val      = bus.up_down ? '0 : bus.rollover_val;
        at_terminal    = bus.up_down ? (value_q >= bus.rollover_val) : (value_q == '0);
        stepped        = bus.up_down ? (value_q + ONE) : (value_q - ONE);
        lands_terminal = bus.up_down ? (stepped >= bus.rollover_val) : (stepped == '0);

        value_d = value_q;
        flag_d  = 1'b0;
        done_d  = done_q;

        if (bus.sync_reset) begin
            value_d = start_val;
            done_d  = 1'b0;
        end else if (bus.load) begin
            value_d = bus.load_val;
            done_d  = 1'b0;
        end else if (bus.count_enable) begin
            if ((bus.mode == MODE_ONE_SHOT) && done_q) begin
                value_d = value_q;
            end else if (at_terminal) begin
                case (bus.mode)
                    MODE_SATURATE: begin
                        done_d = 1'b1;
                    end
                    MODE_ONE_SHOT: begin
                        value_d = start_val;
                        flag_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                    default: begin
                        value_d = start_val;
                        flag_d  = 1'b1;
                    end
                endcase
            end else begin
                value_d = stepped;
                if ((bus.mode == MODE_SATURATE) && lands_terminal) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    assign bus.value         = value_q;
    assign bus.rollover_flag = flag_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_flex_counter_dir.sv
// Directed-vector bench for flex_counter_dir at NUM_CNT_BITS = 4.
module tb_flex_counter_dir;
    import counter_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   error_count = 0;

    flex_counter_dir_if #(.NUM_CNT_BITS(W)) bus ();

    flex_counter_dir #(.NUM_CNT_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic expectState(input string tag, input logic [W-1:0] v, input logic f, input logic d);
        checkOutput({tag, ".value"}, 32'(bus.value), 32'(v));
        checkOutput({tag, ".flag"}, 32'(bus.rollover_flag), 32'(f));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask

    // Drive one cycle's controls, then sample 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic sr, input logic ld, input logic [W-1:0] lv,
                                 input logic en, input logic ud, input cnt_mode_t md,
                                 input logic [W-1:0] rv);
        bus.sync_reset   = sr;
        bus.load         = ld;
        bus.load_val     = lv;
        bus.count_enable = en;
        bus.up_down      = ud;
        bus.mode         = md;
        bus.rollover_val = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] down_seq [7];
        logic [W-1:0] up_seq   [5];
        down_seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
        up_seq   = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

        rst              = 1'b1;
        bus.sync_reset   = 1'b0;
        bus.load         = 1'b0;
        bus.load_val     = '0;
        bus.count_enable = 1'b0;
        bus.up_down      = 1'b0;
        bus.mode         = MODE_WRAP;
        bus.rollover_val = 4'd5;
        #12;
        expectState("reset", 4'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_WRAP, 4'd5);
            expectState($sformatf("wrap_down[%0d]", i), down_seq[i], down_seq[i] == 4'd5, 1'b0);
        end

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, MODE_WRAP, 4'd3);
        expectState("wrap_up_sr", 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd3);
            expectState($sformatf("wrap_up[%0d]", i), up_seq[i], i == 3, 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, MODE_SATURATE, 4'd9);
        expectState("sat_load", 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_SATURATE, 4'd9);
        expectState("sat_8", 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_SATURATE, 4'd9);
            expectState($sformatf("sat_9[%0d]", i), 4'd9, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, MODE_SATURATE, 4'd9);
        expectState("sat_sr", 4'd0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, MODE_ONE_SHOT, 4'd2);
        expectState("os_sr", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_ONE_SHOT, 4'd2);
        expectState("os_1", 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_ONE_SHOT, 4'd2);
        expectState("os_0", 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_ONE_SHOT, 4'd2);
        expectState("os_fire", 4'd2, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_ONE_SHOT, 4'd2);
            checkOutput($sformatf("os_hold[%0d].value", i), 32'(bus.value), 32'd2);
            checkOutput($sformatf("os_hold[%0d].done", i), 32'(bus.done), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, MODE_ONE_SHOT, 4'd2);
        expectState("os_load", 4'd6, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 4'd11, 1'b1, 1'b0, MODE_WRAP, 4'd7);
        expectState("prio", 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, MODE_WRAP, 4'd7);
        expectState("dir_load", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_WRAP, 4'd7);
        expectState("dir_down", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd7);
        expectState("dir_up", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd7);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd7);
        expectState("dir_5", 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd2);
        expectState("rv_lower", 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd2);
        expectState("rv_lower_next", 4'd1, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, MODE_WRAP, 4'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, MODE_WRAP, 4'd0);
            expectState($sformatf("rv0[%0d]", i), 4'd0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_RSVD, 4'd1);
        expectState("rsvd_1", 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_RSVD, 4'd1);
        expectState("rsvd_wrap", 4'd0, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, MODE_WRAP, 4'd15);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd15);
        expectState("pre_rst", 4'd6, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        expectState("async_rst", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        expectState("rst_held", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd15);
        expectState("post_rst_1", 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, MODE_WRAP, 4'd15);
        expectState("post_rst_2", 4'd2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
